ahb_mtx_dec_param: RTL and testbench
====================================

Name: ahb_mtx_dec_param

Overview:
- Parametrised decoder and response multiplexer for one bus-matrix input stage.
- Maps the input-stage address to one of NUM_PORTS output stages. Unmapped or disabled regions go to an integrated two-cycle ERROR default slave.
- Multiplexes the data-phase response back to the input stage.
- Adds a runtime per-port enable and a decode-error capture/counter block for software debug of the camera SoC.

Parameters:
- NUM_PORTS, 3, number of output stages (1..8).
- ADDR_LO, {22'h180248,22'h180244,22'h180100}, flattened lower bounds of decode_addr_dec[31:10]; port i at bits [22i+21:22i]; inclusive.
- ADDR_HI, {22'h18024b,22'h180247,22'h180243}, flattened inclusive upper bounds, same packing.
- DW, 32, HRDATA width.
- UW, 32, HRUSER width.
- CNT_W, 8, error-counter width.

Ports:
- HCLK  in  1  AHB system clock.
- HRESET  in  1  reset, synchronous, active-high.
- HREADYS  in  1  input-stage transfer done.
- sel_dec  in  1  input-stage HSEL.
- decode_addr_dec  in  22  HADDR[31:10].
- trans_dec  in  2  HTRANS.
- port_en  in  NUM_PORTS  per-port region enable; a disabled port never decodes.
- active_in  in  NUM_PORTS  output-stage active flags.
- readyout_in  in  NUM_PORTS  output-stage HREADYOUT.
- resp_in  in  2*NUM_PORTS  output-stage HRESP, port i at [2i+1:2i].
- rdata_in  in  DW*NUM_PORTS  output-stage HRDATA.
- ruser_in  in  UW*NUM_PORTS  output-stage HRUSER.
- err_clr  in  1  clear error capture and counter.
- sel_out  out  NUM_PORTS  one-hot HSEL to output stages.
- active_dec  out  1  active flag of the addressed stage.
- HREADYOUTS  out  1  selected HREADYOUT.
- HRESPS  out  2  selected HRESP.
- HRDATAS  out  DW  selected read data.
- HRUSERS  out  UW  selected user data.
- err_valid  out  1  first unmapped access captured.
- err_addr  out  22  captured decode_addr_dec.
- err_count  out  CNT_W  saturating count of unmapped accesses.

Behaviour:
- Address port addr_port (combinational, width clog2(NUM_PORTS+1); value NUM_PORTS means default slave):
  - The lowest index i wins if (ADDR_LO_i <= addr <= ADDR_HI_i and port_en[i]), or if (data_port == i and trans_dec == IDLE).
  - The IDLE-hold term keeps an idle transfer on the port still in its data phase.
  - No match selects the default slave.
- sel_out[i] = sel_dec & (addr_port == i). Default-slave select = sel_dec & (addr_port == NUM_PORTS). No X outputs for any value.
- active_dec = active_in[addr_port] for a real port; 1 for the default slave.
- data_port register:
  - Loads addr_port on HCLK when HREADYS = 1; holds otherwise.
  - Reset value 0.
  - Data-phase outputs are pure combinational muxes of data_port.
  - For the default slave, HRDATAS = 0 and HRUSERS = 0.
- Default slave FSM, states OKAY / ERR1 / ERR2, reset to OKAY:
  - Decoding of the ERROR request happens in OKAY only. If the default-slave select = 1, HREADYS = 1 and trans_dec[1] = 1, next state is ERR1; otherwise it stays in OKAY.
  - ERR1: readyout = 0, resp = 01 (ERROR); next state is ERR2 unconditionally.
  - ERR2: readyout = 1, resp = 01. The ERR2 cycle is itself a completing cycle (HREADYS high), so a new transfer can be accepted there. Next state is ERR1 if a new NONSEQ/SEQ to the default slave is accepted this cycle; otherwise OKAY.
  - OKAY: readyout = 1, resp = 00.
  - IDLE/BUSY to the default slave gets a zero-wait OKAY.
- Error capture (on the same acceptance event as the FSM, called ev):
  - If ev and !err_valid: err_valid <= 1, err_addr <= decode_addr_dec.
  - If ev: err_count increments, saturating at all-ones.
  - If err_clr and not ev: err_valid = 0, err_count = 0; err_addr is held.
  - If err_clr and ev in the same cycle: err_valid = 1, err_addr = new address, err_count = 1.
- Reset, including mid-transfer: data_port = 0, FSM = OKAY, err_valid = 0, err_addr = 0, err_count = 0.
  - Outputs after reset: HREADYOUTS = readyout_in[0], HRESPS = resp_in[1:0].
  - A wait-stated ERROR is abandoned on reset.
- Latency: address decode 0 cycles. An unmapped NONSEQ completes with a 2-cycle ERROR (ERR1, ERR2) starting the cycle after acceptance.

Test Plan:
- Reset, then NONSEQ at addr 0x180100 with sel_dec = 1, HREADYS = 1 -> sel_out = 001. Next cycle HREADYOUTS/HRDATAS follow port 0. Repeat for 0x180247 -> sel_out = 010 and 0x18024b -> 100.
- port_en = 101, NONSEQ to 0x180245 -> sel_out = 000; then ERR1 (HREADYOUTS = 0, HRESPS = 01), ERR2 (1, 01); err_valid = 1, err_addr = 0x180245, err_count = 1.
- Back-to-back unmapped NONSEQs, second accepted in ERR2 -> ERR1, ERR2, ERR1, ERR2 with no OKAY gap; err_addr keeps the first address; err_count = 2.
- Port 1 data phase stalled (readyout_in[1] = 0), then IDLE with addr 0x000000 -> sel_out = 010 (held), HREADYOUTS = 0 until port 1 is ready. An IDLE to the default slave gets a 1-cycle OKAY.
- err_count at 0xFF plus another error -> stays 0xFF. err_clr in the same cycle as an error -> err_valid = 1, err_count = 1, new err_addr. err_clr alone -> 0, 0.
- HRESET asserted during ERR1 -> next cycle FSM = OKAY, HREADYOUTS = readyout_in[0], err_count = 0.

Source files
------------

// File: rtl/ahb_mtx_dec_param_if.sv
// Bus bundle between one bus-matrix input stage, its decoder/response mux
// and the output stages it can reach. The slave modport is the decoder's
// view; the master modport is the view of whatever drives the decoder.
interface ahb_mtx_dec_param_if #(
  parameter int NUM_PORTS = 3,
  parameter int DW        = 32,
  parameter int UW        = 32
);

  // input-stage address/data phase
  logic                     HREADYS;
  logic                     sel_dec;
  logic [21:0]              decode_addr_dec;
  logic [1:0]               trans_dec;
  logic                     active_dec;
  logic                     HREADYOUTS;
  logic [1:0]               HRESPS;
  logic [DW-1:0]            HRDATAS;
  logic [UW-1:0]            HRUSERS;

  // output-stage side
  logic [NUM_PORTS-1:0]     sel_out;
  logic [NUM_PORTS-1:0]     active_in;
  logic [NUM_PORTS-1:0]     readyout_in;
  logic [2*NUM_PORTS-1:0]   resp_in;
  logic [DW*NUM_PORTS-1:0]  rdata_in;
  logic [UW*NUM_PORTS-1:0]  ruser_in;

  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
    input  active_in, readyout_in, resp_in, rdata_in, ruser_in,
    output active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS, sel_out
  );

  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec,
    output active_in, readyout_in, resp_in, rdata_in, ruser_in,
    input  active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS, sel_out
  );

endinterface

// File: rtl/ahb_mtx_dec_param.sv
// Address decoder and data-phase response mux for one bus-matrix input
// stage. Addresses outside every enabled region go to a built-in default
// slave that answers NONSEQ/SEQ with a two-cycle ERROR. The first unmapped
// access is captured and all unmapped accesses are counted for debug.
module ahb_mtx_dec_param #(
  parameter int                      NUM_PORTS = 3,
  parameter logic [22*NUM_PORTS-1:0] ADDR_LO   = {22'h180248, 22'h180244, 22'h180100},
  parameter logic [22*NUM_PORTS-1:0] ADDR_HI   = {22'h18024b, 22'h180247, 22'h180243},
  parameter int                      DW        = 32,
  parameter int                      UW        = 32,
  parameter int                      CNT_W     = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] port_en,
  input  logic                 err_clr,
  output logic                 err_valid,
  output logic [21:0]          err_addr,
  output logic [CNT_W-1:0]     err_count,
  ahb_mtx_dec_param_if.slave   bus
);

  // Port index NUM_PORTS stands for the default slave.
  localparam int             PW       = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0]  DEF_PORT = PW'(NUM_PORTS);
  localparam logic [1:0]     TRANS_IDLE = 2'b00;

  localparam logic [1:0]     ST_OKAY = 2'd0;
  localparam logic [1:0]     ST_ERR1 = 2'd1;
  localparam logic [1:0]     ST_ERR2 = 2'd2;

  localparam logic [1:0]     RESP_OKAY  = 2'b00;
  localparam logic [1:0]     RESP_ERROR = 2'b01;

  logic [PW-1:0]        addr_port;
  logic [PW-1:0]        data_port;
  logic [1:0]           state_q;
  logic                 def_sel;
  logic                 err_ev;
  logic                 def_ready;
  logic [1:0]           def_resp;
  logic [NUM_PORTS-1:0] sel_vec;
  logic                 active_sel;

  // Address decode: lowest matching port wins; an IDLE stays on the data-phase port.
  always_comb begin
    addr_port = DEF_PORT;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((bus.decode_addr_dec >= ADDR_LO[22*i +: 22] &&
           bus.decode_addr_dec <= ADDR_HI[22*i +: 22] && port_en[i]) ||
          (data_port == PW'(i) && bus.trans_dec == TRANS_IDLE)) begin
        addr_port = PW'(i);
      end
    end
  end

  // One-hot output select and active flag of the addressed stage.
  always_comb begin
    sel_vec    = '0;
    active_sel = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == PW'(i)) begin
        sel_vec[i] = bus.sel_dec;
        active_sel = bus.active_in[i];
      end
    end
  end

  assign bus.sel_out    = sel_vec;
  assign bus.active_dec = active_sel;

  // A NONSEQ/SEQ to the default slave is accepted only when it is not stalling.
  assign def_sel = bus.sel_dec & (addr_port == DEF_PORT);
  assign err_ev  = def_sel & bus.HREADYS & bus.trans_dec[1] & (state_q != ST_ERR1);

  // Data-phase port follows the address phase whenever the input stage completes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      data_port <= '0;
    end else if (bus.HREADYS) begin
      data_port <= addr_port;
    end
  end

  // Default-slave ERROR sequencer; ERR2 may chain straight into another ERR1.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_OKAY;
    end else begin
      case (state_q)
        ST_OKAY: state_q <= err_ev ? ST_ERR1 : ST_OKAY;
        ST_ERR1: state_q <= ST_ERR2;
        ST_ERR2: state_q <= err_ev ? ST_ERR1 : ST_OKAY;
        default: state_q <= ST_OKAY;
      endcase
    end
  end

  assign def_ready = (state_q != ST_ERR1);
  assign def_resp  = (state_q == ST_OKAY) ? RESP_OKAY : RESP_ERROR;

  // Response mux driven purely by the registered data-phase port.
  always_comb begin
    bus.HREADYOUTS = def_ready;
    bus.HRESPS     = def_resp;
    bus.HRDATAS    = '0;
    bus.HRUSERS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port == PW'(i)) begin
        bus.HREADYOUTS = bus.readyout_in[i];
        bus.HRESPS     = bus.resp_in[2*i +: 2];
        bus.HRDATAS    = bus.rdata_in[DW*i +: DW];
        bus.HRUSERS    = bus.ruser_in[UW*i +: UW];
      end
    end
  end

  // Capture the first unmapped address and keep a saturating error count.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (err_ev) begin
      if (!err_valid || err_clr) begin
        err_valid <= 1'b1;
        err_addr  <= bus.decode_addr_dec;
      end
      if (err_clr) begin
        err_count <= CNT_W'(1);
      end else if (err_count != {CNT_W{1'b1}}) begin
        err_count <= err_count + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_mtx_dec_param.sv
// Directed bench for ahb_mtx_dec_param: decode, IDLE hold, default-slave
// ERROR sequencing, error capture/counter and reset behaviour.
module tb_ahb_mtx_dec_param;

  localparam logic [1:0]  IDLE   = 2'b00;
  localparam logic [1:0]  NONSEQ = 2'b10;
  localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD111_1111, D2 = 32'hD222_2222;
  localparam logic [31:0] U0 = 32'h0000_00A0, U1 = 32'h0000_00A1, U2 = 32'h0000_00A2;

  logic       HCLK;
  logic       HRESET;
  logic [2:0] port_en;
  logic       err_clr;
  logic       err_valid;
  logic [21:0] err_addr;
  logic [7:0] err_count;

  logic       nextReset;
  logic [2:0] nextPortEn;
  logic [2:0] nextReady;
  logic [5:0] nextResp;

  int vectors = 0;
  int miscompares = 0;

  ahb_mtx_dec_param_if #(.NUM_PORTS(3), .DW(32), .UW(32)) bus ();

  ahb_mtx_dec_param #(.NUM_PORTS(3), .DW(32), .UW(32), .CNT_W(8)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .port_en   (port_en),
    .err_clr   (err_clr),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_count (err_count),
    .bus       (bus.slave)
  );

  // Single input stage: its HREADY is the muxed HREADYOUT.
  assign bus.HREADYS = bus.HREADYOUTS;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic sel, input logic [21:0] addr,
                               input logic [1:0] trans, input logic clr);
    @(posedge HCLK);
    #1;
    HRESET              = nextReset;
    port_en             = nextPortEn;
    bus.readyout_in     = nextReady;
    bus.resp_in         = nextResp;
    bus.sel_dec         = sel;
    bus.decode_addr_dec = addr;
    bus.trans_dec       = trans;
    err_clr             = clr;
    @(negedge HCLK);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nextReset = 1'b1; nextPortEn = 3'b111; nextReady = 3'b110; nextResp = 6'b00_00_11;
    HRESET = 1'b1; port_en = 3'b111; err_clr = 1'b0;
    bus.sel_dec = 1'b0; bus.decode_addr_dec = '0; bus.trans_dec = IDLE;
    bus.active_in = 3'b101; bus.readyout_in = nextReady; bus.resp_in = nextResp;
    bus.rdata_in = {D2, D1, D0}; bus.ruser_in = {U2, U1, U0};

    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    nextReset = 1'b0;
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("rst_ready", bus.HREADYOUTS, 0);
    checkOutput("rst_resp", bus.HRESPS, 2'b11);
    checkOutput("rst_rdata", bus.HRDATAS, D0);
    checkOutput("rst_sel", bus.sel_out, 0);
    checkOutput("rst_valid", err_valid, 0);
    checkOutput("rst_addr", err_addr, 0);
    checkOutput("rst_count", err_count, 0);

    nextReady = 3'b111; nextResp = 6'b0;
    applyStimulus(1'b1, 22'h180100, NONSEQ, 1'b0);
    checkOutput("p0_sel", bus.sel_out, 3'b001);
    checkOutput("p0_active", bus.active_dec, 1);
    checkOutput("p0_ready", bus.HREADYOUTS, 1);
    applyStimulus(1'b1, 22'h180247, NONSEQ, 1'b0);
    checkOutput("p1_sel", bus.sel_out, 3'b010);
    checkOutput("p1_active", bus.active_dec, 0);
    checkOutput("p0_rdata", bus.HRDATAS, D0);
    checkOutput("p0_ruser", bus.HRUSERS, U0);
    applyStimulus(1'b1, 22'h18024b, NONSEQ, 1'b0);
    checkOutput("p2_sel", bus.sel_out, 3'b100);
    checkOutput("p1_rdata", bus.HRDATAS, D1);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("nosel_sel", bus.sel_out, 3'b000);
    checkOutput("p2_rdata", bus.HRDATAS, D2);
    checkOutput("p2_ruser", bus.HRUSERS, U2);

    nextPortEn = 3'b101;
    applyStimulus(1'b1, 22'h180245, NONSEQ, 1'b0);
    checkOutput("dis_sel", bus.sel_out, 3'b000);
    checkOutput("dis_active", bus.active_dec, 1);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("err1_ready", bus.HREADYOUTS, 0);
    checkOutput("err1_resp", bus.HRESPS, 2'b01);
    checkOutput("def_rdata", bus.HRDATAS, 0);
    checkOutput("cap_valid", err_valid, 1);
    checkOutput("cap_addr", err_addr, 22'h180245);
    checkOutput("cap_count", err_count, 1);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("err2_ready", bus.HREADYOUTS, 1);
    checkOutput("err2_resp", bus.HRESPS, 2'b01);
    applyStimulus(1'b1, 22'h0, IDLE, 1'b1);
    checkOutput("okay_ready", bus.HREADYOUTS, 1);
    checkOutput("okay_resp", bus.HRESPS, 2'b00);

    applyStimulus(1'b1, 22'h000010, NONSEQ, 1'b0);
    checkOutput("idle_def_ready", bus.HREADYOUTS, 1);
    checkOutput("idle_def_resp", bus.HRESPS, 2'b00);
    checkOutput("clr_valid", err_valid, 0);
    checkOutput("clr_count", err_count, 0);
    checkOutput("clr_addr_hold", err_addr, 22'h180245);
    applyStimulus(1'b1, 22'h000020, NONSEQ, 1'b0);
    checkOutput("b2b_err1a_ready", bus.HREADYOUTS, 0);
    checkOutput("b2b_err1a_resp", bus.HRESPS, 2'b01);
    applyStimulus(1'b1, 22'h000020, NONSEQ, 1'b0);
    checkOutput("b2b_err2a_ready", bus.HREADYOUTS, 1);
    checkOutput("b2b_err2a_resp", bus.HRESPS, 2'b01);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("b2b_err1b_ready", bus.HREADYOUTS, 0);
    checkOutput("b2b_err1b_resp", bus.HRESPS, 2'b01);
    checkOutput("b2b_addr", err_addr, 22'h000010);
    checkOutput("b2b_count", err_count, 2);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("b2b_err2b_ready", bus.HREADYOUTS, 1);
    checkOutput("b2b_err2b_resp", bus.HRESPS, 2'b01);

    nextPortEn = 3'b111;
    applyStimulus(1'b1, 22'h180244, NONSEQ, 1'b0);
    checkOutput("hold_req_sel", bus.sel_out, 3'b010);
    checkOutput("hold_req_resp", bus.HRESPS, 2'b00);
    nextReady = 3'b101;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 22'h0, IDLE, 1'b0);
      checkOutput("hold_sel", bus.sel_out, 3'b010);
      checkOutput("hold_stall", bus.HREADYOUTS, 0);
    end
    nextReady = 3'b111;
    applyStimulus(1'b1, 22'h0, IDLE, 1'b0);
    checkOutput("hold_release_sel", bus.sel_out, 3'b010);
    checkOutput("hold_release_ready", bus.HREADYOUTS, 1);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("hold_rdata", bus.HRDATAS, D1);

    for (int i = 0; i < 520; i++) begin
      applyStimulus(1'b1, 22'h3FFFFF, NONSEQ, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    end
    checkOutput("sat_count", err_count, 8'hFF);
    checkOutput("sat_addr", err_addr, 22'h000010);

    applyStimulus(1'b1, 22'h000123, NONSEQ, 1'b1);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("clrev_valid", err_valid, 1);
    checkOutput("clrev_addr", err_addr, 22'h000123);
    checkOutput("clrev_count", err_count, 1);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    applyStimulus(1'b0, 22'h0, IDLE, 1'b1);
    applyStimulus(1'b1, 22'h000200, NONSEQ, 1'b0);
    checkOutput("clr_only_valid", err_valid, 0);
    checkOutput("clr_only_count", err_count, 0);
    checkOutput("clr_only_addr", err_addr, 22'h000123);

    nextReset = 1'b1;
    applyStimulus(1'b1, 22'h000200, NONSEQ, 1'b0);
    checkOutput("pre_rst_err1", bus.HREADYOUTS, 0);
    checkOutput("pre_rst_count", err_count, 1);
    nextReset = 1'b0; nextReady = 3'b110; nextResp = 6'b00_00_10;
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("midrst_ready", bus.HREADYOUTS, 0);
    checkOutput("midrst_resp", bus.HRESPS, 2'b10);
    checkOutput("midrst_count", err_count, 0);
    checkOutput("midrst_valid", err_valid, 0);
    checkOutput("midrst_addr", err_addr, 0);
    nextReady = 3'b111; nextResp = 6'b0;
    applyStimulus(1'b0, 22'h0, IDLE, 1'b0);
    checkOutput("midrst_after_ready", bus.HREADYOUTS, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
